// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide sequencer.
//   - op encodings (MULT, MULTU, DIV, DIVU)
//   - sequencer state encoding
//   - counter-width helper and default operand width
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Iteration counter width for the default operand width.
  localparam int unsigned CNT_W = $clog2(DEF_WIDTH);

  // Counter width for an arbitrary operand width (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // op[1] selects divide, op[0] selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   i_is_div   - 1: restoring-divide step, 0: shift-add multiply step
//   i_acc      - 2*WIDTH accumulator. Multiply: {partial product, multiplier}.
//                Divide: {partial remainder, remaining dividend bits}.
//   i_operand  - multiplicand (multiply) or divisor (divide), unsigned magnitude
//   o_acc_next - accumulator after this step (divide: LSB left 0 for the quotient bit)
//   o_q_bit    - quotient bit produced by a divide step (0 in multiply mode)
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_acc_next,
  output logic                 o_q_bit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current multiplier bit is set;
    // the carry lands in the top bit and the whole accumulator shifts right.
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    // Divide: remainder shifted left with the next dividend bit; no borrow means it fits.
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, i_operand};

    o_q_bit    = 1'b0;
    o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
    if (i_is_div) begin
      o_q_bit    = ~w_diff[WIDTH];
      o_acc_next = {(o_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                    i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports:
//   i_clk, i_reset        - rising-edge clock, synchronous active-high reset
//   i_start, i_op         - one-cycle request and operation (accepted only in IDLE)
//   i_rs_val, i_rt_val    - multiplicand/dividend and multiplier/divisor
//   i_mthi, i_mtlo        - write i_wdata to HI/LO (IDLE only, lower priority than start)
//   o_hi, o_lo            - committed HI/LO values
//   o_busy                - operation in flight (CALC/FIXUP)
//   o_done                - one-cycle pulse after HI/LO update (or div-by-zero)
//   o_div_by_zero         - pulses with o_done when a divide had a zero divisor
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic                 r_is_div;
  logic                 r_neg_q;   // product / quotient sign
  logic                 r_neg_r;   // remainder sign (dividend sign)
  logic                 r_dbz;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_operand;
  logic [CntW-1:0]      r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_is_div;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_div_zero;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_q_bit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  // Operand conditioning at accept time: signed ops work on magnitudes.
  always_comb begin
    w_is_div   = op_is_div(i_op);
    w_a_neg    = op_is_signed(i_op) & i_rs_val[WIDTH-1];
    w_b_neg    = op_is_signed(i_op) & i_rt_val[WIDTH-1];
    w_mag_a    = w_a_neg ? -i_rs_val : i_rs_val;
    w_mag_b    = w_b_neg ? -i_rt_val : i_rt_val;
    w_div_zero = w_is_div & (i_rt_val == '0);
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_is_div   (r_is_div),
    .i_acc      (r_acc),
    .i_operand  (r_operand),
    .o_acc_next (w_acc_next),
    .o_q_bit    (w_q_bit)
  );

  // Sign fix-up of the final magnitudes.
  always_comb begin
    w_prod = r_neg_q ? -r_acc : r_acc;
    w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Next-state and outputs.
  always_comb begin
    w_state_next  = r_state;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_div_by_zero = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = w_div_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        o_busy = 1'b1;
        if (r_cnt == CntLast) w_state_next = S_FIXUP;
      end
      S_FIXUP: begin
        o_busy       = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        o_done        = 1'b1;
        o_div_by_zero = r_dbz;
        w_state_next  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
      r_acc     <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            // Start wins over a same-cycle MTHI/MTLO.
            r_is_div  <= w_is_div;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_dbz     <= w_div_zero;
            r_cnt     <= '0;
            r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_operand <= w_is_div ? w_mag_b : w_mag_a;
          end else begin
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
          end
        end
        S_CALC: begin
          // Quotient bit enters the LSB vacated by the divide shift.
          r_acc <= w_acc_next | {{(2*WIDTH-1){1'b0}}, w_q_bit};
          r_cnt <= r_cnt + CntW'(1);
        end
        S_FIXUP: begin
          if (r_is_div) begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        S_DONE: begin
        end
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH = 32).
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_mthi, i_mtlo;
  logic [1:0]  i_op;
  logic [31:0] i_rs_val, i_rt_val, i_wdata;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_done, o_div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(
    .WIDTH (32)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_rs_val      (i_rs_val),
    .i_rt_val      (i_rt_val),
    .i_mthi        (i_mthi),
    .i_mtlo        (i_mtlo),
    .i_wdata       (i_wdata),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic write_hilo(input logic hi_en, input logic lo_en, input logic [31:0] data);
    @(negedge clk);
    i_mthi  = hi_en;
    i_mtlo  = lo_en;
    i_wdata = data;
    @(negedge clk);
    i_mthi  = 1'b0;
    i_mtlo  = 1'b0;
  endtask

  // Issue one operation and watch busy/done for exp_lat+3 cycles after the start edge.
  // inject: at cycle 5 raise start (DIVU) and mthi=0xDEAD, which must both be ignored.
  // wr_with_start: raise mthi/mtlo=0xBEEF together with start, which must be dropped.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat, input logic exp_dbz,
                        input logic inject, input logic [31:0] exp_mid_hi,
                        input logic wr_with_start);
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic        busy_ok  = 1'b1;
    logic        dbz_seen = 1'b0;
    logic [31:0] mid_hi   = '0;
    @(negedge clk);
    i_start  = 1'b1;
    i_op     = op;
    i_rs_val = a;
    i_rt_val = b;
    i_mthi   = wr_with_start;
    i_mtlo   = wr_with_start;
    i_wdata  = 32'h0000_BEEF;
    for (int k = 1; k <= exp_lat + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_start = 1'b0;
        i_mthi  = 1'b0;
        i_mtlo  = 1'b0;
      end
      if (inject && k == 6) begin
        i_start = 1'b0;
        i_mthi  = 1'b0;
      end
      if (k == 7) mid_hi = o_hi;
      if (o_busy !== (k < exp_lat)) busy_ok = 1'b0;
      if (o_done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = k;
          dbz_seen = o_div_by_zero;
        end
      end
      if (inject && k == 5) begin
        i_start  = 1'b1;
        i_op     = OP_DIVU;
        i_rs_val = 32'd9;
        i_rt_val = 32'd3;
        i_mthi   = 1'b1;
        i_wdata  = 32'h0000_DEAD;
      end
    end
    check({tag, " busy window"}, {31'b0, busy_ok}, 32'd1);
    check({tag, " done cycle"}, done_cyc, exp_lat);
    check({tag, " done pulses"}, done_cnt, 32'd1);
    check({tag, " div_by_zero"}, {31'b0, dbz_seen}, {31'b0, exp_dbz});
    check({tag, " hi"}, o_hi, exp_hi);
    check({tag, " lo"}, o_lo, exp_lo);
    if (inject) check({tag, " hi during calc"}, mid_hi, exp_mid_hi);
  endtask

  initial begin
    int done_cnt;
    i_reset = 1'b1; i_start = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0;
    i_op = OP_MULT; i_rs_val = '0; i_rt_val = '0; i_wdata = '0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("reset hi", o_hi, 32'h0);
    check("reset lo", o_lo, 32'h0);
    check("reset busy", {31'b0, o_busy}, 32'd0);
    check("reset done", {31'b0, o_done}, 32'd0);

    write_hilo(1'b0, 1'b1, 32'h0000_1234);
    check("mtlo lo", o_lo, 32'h0000_1234);
    check("mtlo hi untouched", o_hi, 32'h0);
    write_hilo(1'b1, 1'b1, 32'h0000_CAFE);
    check("mthi+mtlo hi", o_hi, 32'h0000_CAFE);
    check("mthi+mtlo lo", o_lo, 32'h0000_CAFE);

    run_op("MULT -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
           34, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op("MULTU max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
           32'h0000_0001, 34, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           34, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14,
           34, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op("DIV min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
           34, 1'b0, 1'b0, 32'h0, 1'b0);
    run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD,
           34, 1'b0, 1'b0, 32'h0, 1'b0);
    // Previous hi is 1; the mid-op MTHI and start must not disturb it or the result.
    run_op("MULTU 6*7 ignore", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42,
           34, 1'b0, 1'b1, 32'd1, 1'b0);

    write_hilo(1'b1, 1'b0, 32'h0000_AAAA);
    write_hilo(1'b0, 1'b1, 32'h0000_5555);
    check("preload hi", o_hi, 32'h0000_AAAA);
    check("preload lo", o_lo, 32'h0000_5555);
    run_op("DIVU /0", OP_DIVU, 32'd123, 32'd0, 32'h0000_AAAA, 32'h0000_5555,
           1, 1'b1, 1'b0, 32'h0, 1'b0);
    run_op("DIV /0 start+mt", OP_DIV, 32'd5, 32'd0, 32'h0000_AAAA, 32'h0000_5555,
           1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    i_start = 1'b1; i_op = OP_MULT; i_rs_val = 32'hFFFF_FFFD; i_rt_val = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    check("midop busy before reset", {31'b0, o_busy}, 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("midop reset busy", {31'b0, o_busy}, 32'd0);
    check("midop reset hi", o_hi, 32'h0);
    check("midop reset lo", o_lo, 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_busy === 1'b1) done_cnt++;
    end
    check("midop no done/busy after reset", done_cnt, 32'd0);
    check("midop hi stays 0", o_hi, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
